// File: rtl/seg_scanner.sv
// seg_scanner: time-multiplexed driver for an 8-digit, 7-segment display.
// A prescaler paces the digit slots. Each frame shows a snapshot of
// numStorage that is taken at frame end. Optional leading-zero blanking
// is overridden at the edit position, which is marked with the decimal point.
module seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] numStorage,
    input  logic [2:0]  bitSW,
    input  logic        blank_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Active-low hex decode, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      snap_q, snap_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick;

    // Prescaler, slot index and frame-end snapshot.
    always_comb begin
        tick         = (cnt_q == CNT_MAX);
        cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d        = tick ? idx_q + 3'd1 : idx_q;
        snap_d       = snap_q;
        frame_done_d = 1'b0;
        if (tick && (idx_q == 3'd7)) begin
            snap_d       = numStorage;
            frame_done_d = 1'b1;
        end
    end

    // Display decode for the current slot; registered one cycle later.
    always_comb begin
        logic [3:0] nib;
        logic       edit_pos;
        logic       blank;
        nib      = snap_q[{idx_q, 2'b00} +: 4];
        edit_pos = (idx_q == bitSW);
        // Digit k is a leading zero when every nibble from k upward is zero;
        // digit 0 and the edit position are always lit.
        blank    = blank_en && (idx_q != 3'd0) && !edit_pos &&
                   ((snap_q >> {idx_q, 2'b00}) == 32'd0);
        an_d     = ~(8'b1 << idx_q);
        seg_d    = hex_to_seg(nib);
        dp_d     = !edit_pos;
        if (blank) begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    // State and output registers with asynchronous reset to a dark display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            snap_q       <= 32'd0;
            frame_done_q <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
